// File: rtl/imem_prefetch.sv
// Instruction prefetch bridge: streams sequential words into a small FIFO ahead of
// the fetch stage and flushes on any non-sequential fetch address.
module imem_prefetch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        exIns_ren,
   input  logic [31:0] exIns_addr,
   output logic        exIns_valid,
   output logic [31:0] exIns_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_reg, state_next;
   logic [31:0]   fifo_mem [DEPTH];
   logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [31:0]   head_addr_reg, head_addr_next;
   logic [31:0]   fetch_addr_reg, fetch_addr_next;
   logic [CW-1:0] outst_reg, outst_next;
   logic [CW-1:0] discard_reg, discard_next;
   logic          pend_reg, pend_next;
   logic          pend_old_reg, pend_old_next;
   logic [31:0]   pend_addr_reg, pend_addr_next;

   logic [CW-1:0] occupancy;
   logic [CW:0]   budget;
   logic          addr_match;
   logic          hit;
   logic          redirect;
   logic          issue_new;
   logic          granted;
   logic          push;

   assign occupancy  = wr_ptr_reg - rd_ptr_reg;
   assign budget     = {1'b0, outst_reg} + {1'b0, occupancy};
   assign addr_match = exIns_addr[31:2] == head_addr_reg[31:2];
   assign hit        = exIns_ren && (state_reg == ST_RUN) && (occupancy != '0) && addr_match;
   assign redirect   = exIns_ren && ((state_reg == ST_IDLE) || !addr_match);

   // A request that was not granted is held (pend_reg) with its original address,
   // even when a redirect has since made it stale.
   assign issue_new  = (state_reg == ST_RUN) && !pend_reg && !redirect && (budget < DEPTH_C);
   assign mem_req    = pend_reg || issue_new;
   assign mem_addr   = pend_reg ? pend_addr_reg : fetch_addr_reg;
   assign granted    = mem_req && mem_gnt;
   assign push       = mem_rvalid && !redirect && (discard_reg == '0);

   assign exIns_valid = hit;
   assign exIns_in    = hit ? fifo_mem[rd_ptr_reg[AW-1:0]] : 32'h0;

   always_comb begin
      state_next      = state_reg;
      rd_ptr_next     = rd_ptr_reg;
      wr_ptr_next     = wr_ptr_reg;
      head_addr_next  = head_addr_reg;
      fetch_addr_next = fetch_addr_reg;
      outst_next      = outst_reg + CW'(granted) - CW'(mem_rvalid);
      discard_next    = discard_reg;
      pend_next       = mem_req && !mem_gnt;
      pend_addr_next  = mem_addr;
      pend_old_next   = pend_old_reg;

      if (push) wr_ptr_next = wr_ptr_reg + CW'(1);
      if (hit) begin
         rd_ptr_next    = rd_ptr_reg + CW'(1);
         head_addr_next = head_addr_reg + 32'd4;
      end
      // Only a grant for the current stream advances the fetch pointer.
      if (granted && !(pend_reg && pend_old_reg)) fetch_addr_next = fetch_addr_reg + 32'd4;
      if (mem_rvalid && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
      if (!pend_next) pend_old_next = 1'b0;

      if (redirect) begin
         state_next      = ST_RUN;
         rd_ptr_next     = '0;
         wr_ptr_next     = '0;
         head_addr_next  = exIns_addr;
         fetch_addr_next = exIns_addr;
         // Everything granted and not yet returned, plus a still-held request, is old-stream.
         discard_next    = outst_next + CW'(pend_next);
         if (pend_next) pend_old_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_reg      <= ST_IDLE;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         head_addr_reg  <= RESET_ADDR;
         fetch_addr_reg <= RESET_ADDR;
         outst_reg      <= '0;
         discard_reg    <= '0;
         pend_reg       <= 1'b0;
         pend_old_reg   <= 1'b0;
         pend_addr_reg  <= RESET_ADDR;
      end else begin
         state_reg      <= state_next;
         rd_ptr_reg     <= rd_ptr_next;
         wr_ptr_reg     <= wr_ptr_next;
         head_addr_reg  <= head_addr_next;
         fetch_addr_reg <= fetch_addr_next;
         outst_reg      <= outst_next;
         discard_reg    <= discard_next;
         pend_reg       <= pend_next;
         pend_old_reg   <= pend_old_next;
         pend_addr_reg  <= pend_addr_next;
      end
   end

   // Data-only storage; read asynchronously so hits add no latency.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= mem_rdata;
   end

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: random fetch streams and a variable-latency memory,
// checked against a request scoreboard and a queue of words the block should hold.
module tb_imem_prefetch;
   localparam int          DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        exIns_ren = 1'b0;
   logic [31:0] exIns_addr = 32'h0;
   logic        exIns_valid;
   logic [31:0] exIns_in;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   always #5 clk = ~clk;

   imem_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
      .clk(clk), .nrst(nrst),
      .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
      .exIns_valid(exIns_valid), .exIns_in(exIns_in),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   mreq_t       mq[$];      // granted requests not yet returned, in order
   logic [31:0] word_q[$];  // addresses of words the block should currently hold
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          started = 0;
   logic [31:0] head = 32'h0;
   logic [31:0] exp_fetch = 32'h0;
   bit          pend_prev = 0;
   bit          pend_stale = 0;
   logic [31:0] pend_addr = 32'h0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          gnt_pct = 100;
   bit          last_hit = 0;
   int          hit_cyc = 0;
   logic [31:0] hit_data = 32'h0;
   bit          saw_zero = 0;
   logic [31:0] pc = 32'h0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] r;
      r = $urandom;
      case (r[1:0])
         2'd0:    return 32'h0000_0200;
         2'd1:    return 32'hFFFF_FFF0;
         default: return {18'h0, r[13:2], 2'b00};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive core and memory, compare outputs, advance the reference model.
   task automatic tick(input logic ren_i, input logic [31:0] addr_i);
      mreq_t ret;
      bit    ret_v, redirect, exp_req, exp_hit, stale_req, gnt;
      int    outst_now;
      @(negedge clk);
      exIns_ren  = ren_i;
      exIns_addr = addr_i;
      outst_now  = mq.size();
      ret_v      = 0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         ret   = mq.pop_front();
         ret_v = 1;
      end
      mem_rvalid = ret_v;
      mem_rdata  = ret_v ? memfn(ret.addr) : $urandom;
      mem_gnt    = 1'b0;
      #1;
      redirect = ren_i && (!started || addr_i[31:2] != head[31:2]);
      exp_req  = pend_prev || (started && !redirect && (outst_now + word_q.size() < DEPTH));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (pend_prev) check("addr_hold", mem_addr, pend_addr);
      else if (mem_req) check("req_addr", mem_addr, exp_fetch);
      gnt     = mem_req && ($urandom_range(99) < gnt_pct);
      mem_gnt = gnt;
      #1;
      exp_hit = ren_i && started && word_q.size() > 0 && word_q[0][31:2] == addr_i[31:2];
      check("valid", 32'(exIns_valid), 32'(exp_hit));
      check("rdata", exIns_in, exp_hit ? memfn(word_q[0]) : 32'h0);
      last_hit = exp_hit;
      if (exp_hit) begin
         $display("fetch addr=%08h data=%08h cycle=%0d", addr_i, exIns_in, cyc);
         if (addr_i == 32'h0) saw_zero = 1;
         hit_data = exIns_in;
         hit_cyc  = cyc;
         void'(word_q.pop_front());
         head = head + 32'd4;
      end
      if (ret_v && !ret.stale && !redirect) word_q.push_back(ret.addr);
      if (redirect) begin
         foreach (mq[i]) mq[i].stale = 1;
         word_q.delete();
         head      = addr_i;
         exp_fetch = addr_i;
         started   = 1;
      end
      stale_req = pend_stale || redirect;
      if (gnt) begin
         mq.push_back('{addr: mem_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), stale: stale_req});
         if (!stale_req) exp_fetch = exp_fetch + 32'd4;
      end
      check("budget", (mq.size() + word_q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
      pend_prev  = mem_req && !gnt;
      pend_addr  = mem_addr;
      pend_stale = pend_prev && stale_req;
      cyc++;
   endtask

   // Fetch from target until the first word arrives; exp_lat < 0 only requires arrival.
   task automatic first_hit(input logic [31:0] target, input int exp_lat);
      int t0, lat;
      t0 = cyc;
      pc = target;
      tick(1'b1, pc);
      lat = -1;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         tick(1'b1, pc);
         if (last_hit) begin
            lat = hit_cyc - t0;
            pc  = pc + 32'd4;
         end
      end
      if (exp_lat >= 0) check("miss_lat", 32'(lat), 32'(exp_lat));
      else check("hit_seen", (lat >= 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic run(input int n, input int branch_pct, input int ren_pct);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < branch_pct) pc = pick();
         tick($urandom_range(99) < ren_pct, pc);
         if (last_hit) pc = pc + 32'd4;
      end
   endtask

   task automatic reset_mid();
      @(negedge clk);
      #2;
      nrst = 1'b1;
      #1;
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_valid", 32'(exIns_valid), 32'd0);
      check("rst_in", exIns_in, 32'h0);
      check("rst_addr", mem_addr, RESET_ADDR);
      exIns_ren  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      @(negedge clk);
      nrst = 1'b0;
      mq.delete();
      word_q.delete();
      started    = 0;
      pend_prev  = 0;
      pend_stale = 0;
   endtask

   initial begin
      int hits;
      exIns_ren  = 1'b1;
      exIns_addr = 32'h100;
      repeat (2) @(negedge clk);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_valid", 32'(exIns_valid), 32'd0);
      check("rst_in", exIns_in, 32'h0);
      check("rst_addr", mem_addr, RESET_ADDR);
      exIns_ren = 1'b0;
      nrst      = 1'b0;
      tick(1'b0, 32'h100);

      // zero-wait memory: miss latency and sustained rate
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      first_hit(32'h100, 3);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, pc);
         if (last_hit) begin
            hits++;
            pc = pc + 32'd4;
         end
      end
      check("stream_rate", 32'(hits), 32'd10);

      // five-cycle memory
      lat_min = 5; lat_max = 5;
      first_hit(32'h300, 7);
      run(30, 0, 100);

      // branch away while requests are in flight
      lat_min = 4; lat_max = 4;
      first_hit(32'h100, -1);
      for (int i = 0; i < 20 && pc != 32'h10C; i++) begin
         tick(1'b1, pc);
         if (last_hit) pc = pc + 32'd4;
      end
      check("reach_108", pc, 32'h10C);
      first_hit(32'h200, -1);
      check("branch_data", hit_data, memfn(32'h200));

      // redirect while a request is stalled without grant
      lat_min = 1; lat_max = 1;
      repeat (8) tick(1'b0, pc);
      gnt_pct = 0;
      tick(1'b1, 32'h600);
      tick(1'b1, 32'h600);
      tick(1'b1, 32'h600);
      check("stall_req", 32'(mem_req), 32'd1);
      tick(1'b1, 32'h700);
      repeat (4) tick(1'b1, 32'h700);
      check("stall_addr", mem_addr, 32'h600);
      gnt_pct = 100;
      first_hit(32'h700, -1);
      check("stall_data", hit_data, memfn(32'h700));

      // address wrap
      first_hit(32'hFFFF_FFF8, -1);
      saw_zero = 0;
      run(6, 0, 100);
      check("wrap_hit", 32'(saw_zero), 32'd1);

      // random traffic
      lat_min = 1; lat_max = 6; gnt_pct = 60;
      run(1500, 4, 85);

      // reset in the middle of a stream, then a clean restart
      lat_min = 2; lat_max = 2; gnt_pct = 100;
      run(20, 0, 100);
      reset_mid();
      lat_min = 1; lat_max = 1;
      first_hit(32'h100, 3);
      run(20, 0, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
